vending_controller: RTL and testbench
=====================================

// Module: vending_controller
// PURPOSE
//  Parametrised multi-product vending controller; successor of the single-board coffee/tea machine.
//  Accepts coin-button presses, product selection and cancel. Tracks credit against the selected price.
//  Issues a dispense pulse and a change/refund amount. Drives two active-low 7-segment digits.
//  Sits between the board button/switch inputs and the LEDs/HEX displays.
// PARAMETERS
//  NUM_PRODUCTS   4                 number of selectable products
//  NUM_COINS      4                 number of coin buttons
//  PRICES         {8'd15,8'd10,8'd12,8'd20}  packed 8b price per product, product 0 in LSBs, each 1..99
//  COIN_VALUES    {8'd5,8'd3,8'd2,8'd1}      packed 8b value per coin button, button 0 in LSBs
//  MAX_CREDIT     99                credit ceiling; must stay <= 99 (two decimal digits)
//  TIMEOUT_CYCLES 250_000_000       idle cycles in PAY before automatic refund
// PORTS
//  clk            in   1             system clock
//  reset          in   1             asynchronous, active-high reset
//  coin_btn       in   NUM_COINS     raw coin buttons, active-low; a press is a 1->0 transition
//  select         in   NUM_PRODUCTS  level product-select switches/buttons, active-high
//  cancel         in   1             level cancel request, active-high
//  product_led    out  NUM_PRODUCTS  one-hot LED of the selected product
//  dispense       out  1             1-cycle pulse: product released
//  dispense_id    out  $clog2(NUM_PRODUCTS)  product index; valid when dispense=1
//  change_valid   out  1             1-cycle pulse: change_amount valid (change or refund)
//  change_amount  out  7             amount returned to the customer
//  coin_reject    out  1             1-cycle pulse: coin refused (saturation or wrong state)
//  disp_low       out  7             units digit, segments {g..a}, active-low
//  disp_high      out  7             tens digit, segments {g..a}, active-low
// BEHAVIOUR
//  Reset: state=IDLE, credit=0, sel=0. All outputs 0 except disp_* = 7'b1000000 ("0").
//  Sync flops reset to 1 so that reset release produces no spurious edge.
//  Coin input path:
//   - Each coin_btn passes through a 2-flop synchroniser; a press is detected as sync1=1 and sync0=0.
//   - credit is updated on the next clk edge. Latency: raw low sampled at edge k -> credit updated at edge k+2.
//  Simultaneous coin edges in one cycle are summed; no coin is lost.
//   - If credit+sum > MAX_CREDIT, the whole cycle's sum is rejected.
//   - On rejection: coin_reject=1 and credit is unchanged.
//  Coins are accepted in IDLE and PAY. In VEND/CHANGE they are rejected (coin_reject).
//  select: lowest set bit wins.
//   - Sampled in IDLE and PAY only.
//   - A new selection in PAY replaces the old one and clears the timeout counter.
//  States:
//   - IDLE: no product selected.
//     - select -> PAY.
//     - cancel with credit>0 -> CHANGE.
//     - credit is shown on the display.
//   - PAY: shows price-credit, or 0 if credit >= price.
//     - credit >= price -> VEND.
//     - cancel, or timeout counter == TIMEOUT_CYCLES-1 -> CHANGE.
//     - The timeout counter clears on every accepted coin.
//     - Cancel has priority over reaching the price in the same cycle.
//   - VEND: one cycle.
//     - Actions: dispense=1, dispense_id=sel, credit <= credit-price, sel cleared.
//     - Next state: CHANGE if the remainder is > 0, else IDLE.
//   - CHANGE: one cycle.
//     - Actions: change_valid=1, change_amount=credit, credit <= 0, display shows the amount.
//     - Next state: IDLE.
//  Arithmetic:
//   - credit is 7b unsigned and never exceeds MAX_CREDIT.
//   - Subtraction happens only when credit >= price, so there is no underflow.
//  Display: value 0..99 is split into tens and units with a compare/subtract (no divider).
//   - Outputs are registered: 1 cycle after the value changes.
//  Reset mid-transaction: credit is discarded and no change_valid is issued.
//  product_led = one-hot(sel) in PAY/VEND, else 0.
// STRUCTURE
//  vending_pkg:
//   - state encoding localparams (IDLE, PAY, VEND, CHANGE).
//   - SEG_DIGITS[0:9] active-low segment constants.
//   - function bin2bcd_2digit.
//  Sub-module seg7_decoder (4b digit -> 7b active-low; default pattern 7'b1001000). Instantiated twice.
//  Synchroniser/edge detect is inline (generate loop over NUM_COINS).
// TESTING
//  1 Select product 1 (price 10); press coins 5,3,2.
//    -> display 10,5,2,0; dispense id=1; no change_valid.
//  2 Select product 0 (price 15); press coins 5,5,3,3.
//    -> dispense id=0; change_valid with amount 1; IDLE.
//  3 Press coins 0 and 3 in the same cycle (1+5).
//    -> credit +6. Then with credit 97, press 3 -> coin_reject, credit stays 97.
//  4 Select product 3; insert 7; cancel.
//    -> change_valid amount 7, no dispense. Repeat without cancel -> refund after TIMEOUT_CYCLES (bench overrides it to 20).
//  5 Assert reset mid-PAY with credit 8.
//    -> all outputs 0, display "0". No spurious coin when reset releases with buttons held high.
//  6 In PAY (price 10, credit 8), press coin 1 (+2) and cancel in the same cycle.
//    -> CHANGE with amount 10, no dispense.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types, segment constants and BCD helper for the vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAY    = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGITS [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Shown for any nibble outside 0..9
    localparam logic [6:0] SEG_DEFAULT = 7'b1001000;

    // Split 0..99 into {tens, units} by repeated compare/subtract
    function automatic logic [7:0] bin2bcd_2digit(input logic [6:0] value);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = value;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One decimal digit to active-low 7-segment pattern.
import vending_pkg::*;

module seg7_decoder (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup; anything above 9 shows the fallback pattern
    always_comb begin
        seg = SEG_DEFAULT;
        case (digit)
            4'd0: seg = SEG_DIGITS[0];
            4'd1: seg = SEG_DIGITS[1];
            4'd2: seg = SEG_DIGITS[2];
            4'd3: seg = SEG_DIGITS[3];
            4'd4: seg = SEG_DIGITS[4];
            4'd5: seg = SEG_DIGITS[5];
            4'd6: seg = SEG_DIGITS[6];
            4'd7: seg = SEG_DIGITS[7];
            4'd8: seg = SEG_DIGITS[8];
            4'd9: seg = SEG_DIGITS[9];
            default: seg = SEG_DEFAULT;
        endcase
    end

endmodule

// File: rtl/vending_controller.sv
// Multi-product vending controller: coin credit, product selection, dispense,
// change/refund and a two-digit active-low display.
import vending_pkg::*;

module vending_controller #(
    parameter int                          NUM_PRODUCTS   = 4,
    parameter int                          NUM_COINS      = 4,
    parameter logic [8*NUM_PRODUCTS-1:0]   PRICES         = {8'd15, 8'd10, 8'd12, 8'd20},
    parameter logic [8*NUM_COINS-1:0]      COIN_VALUES    = {8'd5, 8'd3, 8'd2, 8'd1},
    parameter int                          MAX_CREDIT     = 99,
    parameter int                          TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_COINS-1:0]            coin_btn,
    input  logic [NUM_PRODUCTS-1:0]         select,
    input  logic                            cancel,
    output logic [NUM_PRODUCTS-1:0]         product_led,
    output logic                            dispense,
    output logic [$clog2(NUM_PRODUCTS)-1:0] dispense_id,
    output logic                            change_valid,
    output logic [6:0]                      change_amount,
    output logic                            coin_reject,
    output logic [6:0]                      disp_low,
    output logic [6:0]                      disp_high
);

    localparam int ID_W  = $clog2(NUM_PRODUCTS);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SUM_W = 8 + $clog2(NUM_COINS + 1);

    state_t             state, state_nxt;
    logic [6:0]         credit, credit_nxt;
    logic [ID_W-1:0]    sel, sel_nxt, sel_idx;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [NUM_COINS-1:0] coin_press;
    logic [SUM_W-1:0]   coin_sum, credit_plus;
    logic               coin_any, coins_open, coin_ok, sel_any;
    logic [7:0]         price_sel;
    logic [6:0]         disp_value;
    logic [7:0]         bcd;
    logic [6:0]         seg_low, seg_high;

    genvar g;
    generate
        for (g = 0; g < NUM_COINS; g++) begin : g_coin_sync
            logic meta, sync0, sync1;
            // Two-flop synchroniser plus history flop; idle-high so reset release is edge-free
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    meta  <= 1'b1;
                    sync0 <= 1'b1;
                    sync1 <= 1'b1;
                end else begin
                    meta  <= coin_btn[g];
                    sync0 <= meta;
                    sync1 <= sync0;
                end
            end
            assign coin_press[g] = sync1 & ~sync0;
        end
    endgenerate

    // Sum all coins pressed this cycle and decide accept/reject as one unit
    always_comb begin
        coin_sum = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (coin_press[i]) coin_sum = coin_sum + SUM_W'(COIN_VALUES[8*i +: 8]);
        end
        credit_plus = SUM_W'(credit) + coin_sum;
        coin_any    = |coin_press;
        coins_open  = (state == IDLE) || (state == PAY);
        coin_ok     = coins_open && coin_any && (credit_plus <= SUM_W'(MAX_CREDIT));
        coin_reject = coin_any && !coin_ok;
    end

    // Lowest set select bit wins
    always_comb begin
        sel_any = |select;
        sel_idx = '0;
        for (int i = NUM_PRODUCTS - 1; i >= 0; i--) begin
            if (select[i]) sel_idx = ID_W'(i);
        end
    end

    assign price_sel = PRICES[8*sel +: 8];

    // Next-state, credit bookkeeping and per-state outputs
    always_comb begin
        state_nxt     = state;
        credit_nxt    = credit;
        sel_nxt       = sel;
        timer_nxt     = '0;
        dispense      = 1'b0;
        dispense_id   = '0;
        change_valid  = 1'b0;
        change_amount = '0;
        disp_value    = credit;
        if (coin_ok) credit_nxt = credit_plus[6:0];
        case (state)
            IDLE: begin
                if (sel_any) begin
                    sel_nxt   = sel_idx;
                    state_nxt = PAY;
                end else if (cancel && credit != 7'd0) begin
                    state_nxt = CHANGE;
                end
            end
            PAY: begin
                disp_value = ({1'b0, credit} >= price_sel) ? 7'd0 : price_sel[6:0] - credit;
                timer_nxt  = timer + 1'b1;
                if (coin_ok) timer_nxt = '0;
                if (sel_any) begin
                    sel_nxt   = sel_idx;
                    timer_nxt = '0;
                end
                // A selection arriving this cycle may change the price, so vend waits a cycle
                if (cancel || timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = CHANGE;
                end else if (!sel_any && {1'b0, credit} >= price_sel) begin
                    state_nxt = VEND;
                end
            end
            VEND: begin
                dispense    = 1'b1;
                dispense_id = sel;
                credit_nxt  = credit - price_sel[6:0];
                sel_nxt     = '0;
                state_nxt   = ({1'b0, credit} != price_sel) ? CHANGE : IDLE;
            end
            CHANGE: begin
                change_valid  = 1'b1;
                change_amount = credit;
                credit_nxt    = 7'd0;
                sel_nxt       = '0;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            credit <= 7'd0;
            sel    <= '0;
            timer  <= '0;
        end else begin
            state  <= state_nxt;
            credit <= credit_nxt;
            sel    <= sel_nxt;
            timer  <= timer_nxt;
        end
    end

    assign product_led = (state == PAY || state == VEND) ? (NUM_PRODUCTS'(1) << sel) : '0;

    assign bcd = bin2bcd_2digit(disp_value);

    seg7_decoder u_seg_low  (.digit(bcd[3:0]), .seg(seg_low));
    seg7_decoder u_seg_high (.digit(bcd[7:4]), .seg(seg_high));

    // Registered display so the HEX pins are glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_low  <= SEG_DIGITS[0];
            disp_high <= SEG_DIGITS[0];
        end else begin
            disp_low  <= seg_low;
            disp_high <= seg_high;
        end
    end

endmodule

// File: tb/tb_vending_controller.sv
// Scoreboard bench for vending_controller: stimulus queues expected dispense,
// change and reject events; a monitor pops them as the DUT raises each pulse.
module tb_vending_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] coin_btn = 4'hF;
    logic [3:0] select = 4'h0;
    logic       cancel = 1'b0;
    logic [3:0] product_led;
    logic       dispense;
    logic [1:0] dispense_id;
    logic       change_valid;
    logic [6:0] change_amount;
    logic       coin_reject;
    logic [6:0] disp_low, disp_high;

    int checks = 0;
    int errors = 0;
    int exp_disp_q[$];
    int exp_chg_q[$];
    int exp_rej_q[$];

    // Product prices ordered so product0=15, product1=10, product2=12, product3=20
    vending_controller #(
        .NUM_PRODUCTS(4), .NUM_COINS(4),
        .PRICES({8'd20, 8'd12, 8'd10, 8'd15}),
        .COIN_VALUES({8'd5, 8'd3, 8'd2, 8'd1}),
        .MAX_CREDIT(99), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .reset(reset), .coin_btn(coin_btn), .select(select), .cancel(cancel),
        .product_led(product_led), .dispense(dispense), .dispense_id(dispense_id),
        .change_valid(change_valid), .change_amount(change_amount), .coin_reject(coin_reject),
        .disp_low(disp_low), .disp_high(disp_high)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000;  default: return 7'b1001000;
        endcase
    endfunction

    // Monitor: pops the matching queue whenever the DUT presents a pulse
    always @(negedge clk) begin
        int e;
        if (!reset) begin
            if (dispense) begin
                checks++;
                if (exp_disp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dispense_unexpected: got id %0d, required no dispense", dispense_id);
                end else begin
                    e = exp_disp_q.pop_front();
                    if (int'(dispense_id) != e) begin
                        errors++;
                        $display("FAIL dispense_id: got %0d, required %0d", dispense_id, e);
                    end
                end
            end
            if (change_valid) begin
                checks++;
                if (exp_chg_q.size() == 0) begin
                    errors++;
                    $display("FAIL change_unexpected: got amount %0d, required no change", change_amount);
                end else begin
                    e = exp_chg_q.pop_front();
                    if (int'(change_amount) != e) begin
                        errors++;
                        $display("FAIL change_amount: got %0d, required %0d", change_amount, e);
                    end
                end
            end
            if (coin_reject) begin
                checks++;
                if (exp_rej_q.size() == 0) begin
                    errors++;
                    $display("FAIL reject_unexpected: got coin_reject=1, required 0");
                end else begin
                    e = exp_rej_q.pop_front();
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask);
        @(negedge clk);
        coin_btn = ~mask;
        tick(3);
        coin_btn = 4'hF;
        tick(3);
    endtask

    task automatic choose(input logic [3:0] mask);
        @(negedge clk);
        select = mask;
        @(negedge clk);
        select = 4'h0;
    endtask

    task automatic pulse_cancel();
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic check_val(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic check_disp(input string name, input int value);
        logic [6:0] el, eh;
        tick(3);
        el = seg_ref(value % 10);
        eh = seg_ref(value / 10);
        checks++;
        if (disp_low !== el || disp_high !== eh) begin
            errors++;
            $display("FAIL %s: display %b_%b, required %b_%b (value %0d)",
                     name, disp_high, disp_low, eh, el, value);
        end
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while ((exp_disp_q.size() + exp_chg_q.size() + exp_rej_q.size()) != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((exp_disp_q.size() + exp_chg_q.size() + exp_rej_q.size()) != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events outstanding, required 0", name,
                     exp_disp_q.size() + exp_chg_q.size() + exp_rej_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, "_led"}, int'(product_led), 0);
        check_val({name, "_pulses"}, int'({dispense, change_valid, coin_reject}), 0);
        check_val({name, "_id_amt"}, int'({dispense_id, change_amount}), 0);
        check_val({name, "_disp"}, int'({disp_high, disp_low}), int'({7'b1000000, 7'b1000000}));
    endtask

    initial begin
        tick(2);
        check_reset_outputs("reset_init");
        reset = 1'b0;
        tick(2);

        // 1: product 1 (price 10), coins 5,3,2 -> exact payment
        choose(4'b0010);
        check_disp("t1_price", 10);
        check_val("t1_led", int'(product_led), 4'b0010);
        press(4'b1000);
        check_disp("t1_after5", 5);
        press(4'b0100);
        check_disp("t1_after3", 2);
        exp_disp_q.push_back(1);
        press(4'b0010);
        check_disp("t1_done", 0);
        check_val("t1_led_idle", int'(product_led), 0);
        wait_drain("t1_drain", 10);

        // 2: product 0 (price 15), coins 5,5,3,3 -> dispense and change 1
        choose(4'b0001);
        check_disp("t2_price", 15);
        press(4'b1000);
        press(4'b1000);
        press(4'b0100);
        check_disp("t2_owed", 2);
        exp_disp_q.push_back(0);
        exp_chg_q.push_back(1);
        press(4'b0100);
        check_disp("t2_done", 0);
        wait_drain("t2_drain", 10);

        // 3: simultaneous coins, saturation reject, exact ceiling
        press(4'b1001);
        check_disp("t3_sum6", 6);
        for (int i = 0; i < 18; i++) press(4'b1000);
        press(4'b0001);
        check_disp("t3_97", 97);
        exp_rej_q.push_back(1);
        press(4'b1000);
        check_disp("t3_reject_keeps", 97);
        press(4'b0010);
        check_disp("t3_ceiling99", 99);
        exp_chg_q.push_back(99);
        pulse_cancel();
        check_disp("t3_refund", 0);
        wait_drain("t3_drain", 10);

        // 4: product 3, insert 7, cancel; then the same without cancel -> timeout refund
        choose(4'b1000);
        check_disp("t4_price", 20);
        press(4'b1000);
        press(4'b0010);
        check_disp("t4_owed", 13);
        exp_chg_q.push_back(7);
        pulse_cancel();
        check_disp("t4_cancelled", 0);
        wait_drain("t4_cancel_drain", 10);
        choose(4'b1000);
        press(4'b1000);
        press(4'b0010);
        exp_chg_q.push_back(7);
        wait_drain("t4_timeout", 60);
        check_disp("t4_after_timeout", 0);

        // 5: reset mid-PAY with credit 8
        choose(4'b1000);
        press(4'b1000);
        press(4'b0100);
        check_disp("t5_owed", 12);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("t5_reset");
        tick(2);
        reset = 1'b0;
        tick(5);
        check_disp("t5_after_release", 0);
        check_val("t5_led", int'(product_led), 0);

        // 6: price 10, credit 8, coin +2 and cancel in the same cycle -> refund 10
        choose(4'b0010);
        press(4'b1000);
        press(4'b0100);
        check_disp("t6_owed", 2);
        exp_chg_q.push_back(10);
        @(negedge clk);
        coin_btn = 4'b1101;
        @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        coin_btn = 4'hF;
        wait_drain("t6_drain", 20);
        check_disp("t6_done", 0);

        tick(5);
        wait_drain("final_drain", 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
